// File: rtl/secded_retry_tx.sv
// Transmit-side retry controller for the SECDED link: host byte in, write/read/await ack-nack, retransmit, report.
// Optional statistics counters are compiled in with `define SECDED_TX_STATS_EN.
module secded_retry_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_RETRY  = 3,
  parameter int TIMEOUT    = 15,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [1:0]            s_err_mode,
  output logic                  s_ready,
  output logic                  link_wr_en,
  output logic [DATA_WIDTH-1:0] link_data,
  output logic                  link_rd_en,
  output logic [1:0]            link_err,
  input  logic                  link_ack,
  input  logic                  link_nack,
  input  logic [DATA_WIDTH-1:0] link_rx_data,
`ifdef SECDED_TX_STATS_EN
  output logic [CNT_W-1:0]      stat_ack,
  output logic [CNT_W-1:0]      stat_nack,
  output logic [CNT_W-1:0]      stat_fail,
`endif
  output logic                  res_valid,
  output logic                  res_ok,
  output logic [3:0]            res_retries,
  output logic                  res_timeout,
  output logic                  res_mismatch
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, WR, RD, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0]            err_q, err_d;
  logic [3:0]            retries_q, retries_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic                  ok_q, ok_d;
  logic [3:0]            rres_q, rres_d;
  logic                  tmo_q, tmo_d;
  logic                  mis_q, mis_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      data_q    <= '0;
      err_q     <= '0;
      retries_q <= '0;
      timer_q   <= '0;
      ok_q      <= 1'b0;
      rres_q    <= '0;
      tmo_q     <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      err_q     <= err_d;
      retries_q <= retries_d;
      timer_q   <= timer_d;
      ok_q      <= ok_d;
      rres_q    <= rres_d;
      tmo_q     <= tmo_d;
      mis_q     <= mis_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    err_d     = err_q;
    retries_d = retries_q;
    timer_d   = timer_q;
    ok_d      = ok_q;
    rres_d    = rres_q;
    tmo_d     = tmo_q;
    mis_d     = mis_q;
    case (state_q)
      IDLE: begin
        if (s_valid) begin
          data_d    = s_data;
          err_d     = s_err_mode;
          retries_d = '0;
          state_d   = WR;
        end
      end
      WR: state_d = RD;
      RD: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + TMR_W'(1);
        // nack wins over ack; timeout only when the link stays silent
        if (link_nack) begin
          if (retries_q < 4'(MAX_RETRY)) begin
            retries_d = retries_q + 4'd1;
            state_d   = WR;
          end else begin
            state_d = RESP;
            ok_d    = 1'b0;
            rres_d  = retries_q;
            tmo_d   = 1'b0;
            mis_d   = 1'b0;
          end
        end else if (link_ack) begin
          state_d = RESP;
          ok_d    = (link_rx_data == data_q);
          rres_d  = retries_q;
          tmo_d   = 1'b0;
          mis_d   = (link_rx_data != data_q);
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          state_d = RESP;
          ok_d    = 1'b0;
          rres_d  = retries_q;
          tmo_d   = 1'b1;
          mis_d   = 1'b0;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes decode straight from the state so an async reset drops them immediately
  assign s_ready      = (state_q == IDLE);
  assign link_wr_en   = (state_q == WR);
  assign link_rd_en   = (state_q == RD);
  assign link_err     = (state_q == RD && retries_q == 4'd0) ? err_q : 2'b00;
  assign link_data    = data_q;
  assign res_valid    = (state_q == RESP);
  assign res_ok       = ok_q;
  assign res_retries  = rres_q;
  assign res_timeout  = tmo_q;
  assign res_mismatch = mis_q;

`ifdef SECDED_TX_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  logic [CNT_W-1:0] ack_cnt_q, nack_cnt_q, fail_cnt_q;
  logic             ack_evt, nack_evt, fail_evt;

  assign nack_evt = (state_q == WAIT) && link_nack;
  assign ack_evt  = (state_q == WAIT) && !link_nack && link_ack;
  assign fail_evt = (state_q == WAIT) && (state_d == RESP) && !ok_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_cnt_q  <= '0;
      nack_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      ack_cnt_q  <= sat_inc(ack_cnt_q, ack_evt);
      nack_cnt_q <= sat_inc(nack_cnt_q, nack_evt);
      fail_cnt_q <= sat_inc(fail_cnt_q, fail_evt);
    end
  end

  assign stat_ack  = ack_cnt_q;
  assign stat_nack = nack_cnt_q;
  assign stat_fail = fail_cnt_q;
`endif

endmodule
